// File: rtl/sdram_sched_pkg.sv
// Shared types and default sizing for the SDRAM port scheduler.
package sdram_sched_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    localparam int DEF_BURST_LEN  = 128;
    localparam int DEF_FIFO_DEPTH = 512;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int NPORT  = 4,
    parameter int PORT_W = $clog2(NPORT)
) (
    input  logic [NPORT-1:0]  req,
    input  logic [PORT_W-1:0] ptr,
    output logic [NPORT-1:0]  gnt
);
    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NPORT; k++) begin
            idx = (int'(ptr) + k) % NPORT;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sdram_port_scheduler.sv
// Schedules fixed-length SDRAM bursts among FIFO ports, each walking a
// circular address region; one command in flight at a time.
module sdram_port_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int NPORT      = 4,
    parameter int ADDR_W     = 24,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int LEN_W      = 9,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1,
    parameter int PORT_W     = $clog2(NPORT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NPORT-1:0]        port_en,
    input  logic [NPORT-1:0]        port_dir,
    input  logic [NPORT*ADDR_W-1:0] port_base,
    input  logic [NPORT*ADDR_W-1:0] port_max,
    input  logic [NPORT-1:0]        port_load,
    input  logic [NPORT*LVL_W-1:0]  port_level,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic                    cmd_write,
    output logic [ADDR_W-1:0]       cmd_addr,
    output logic [LEN_W-1:0]        cmd_len,
    output logic [PORT_W-1:0]       cmd_port,
    input  logic                    burst_done,
    output logic [NPORT-1:0]        grant,
    output logic [NPORT-1:0]        wrap
);
    localparam logic [ADDR_W:0] BURST_EXT = (ADDR_W+1)'(BURST_LEN);

    state_t                   state_reg, state_next;
    logic [PORT_W-1:0]        win_reg, ptr_reg, arb_idx;
    logic [NPORT-1:0]         elig, arb_gnt, wrap_bus;
    logic                     cmd_write_reg;
    logic [ADDR_W-1:0]        cmd_addr_reg;
    logic [LEN_W-1:0]         cmd_len_reg;
    logic [NPORT*ADDR_W-1:0]  addr_flat;
    logic                     launch, done;
    logic [ADDR_W-1:0]        sel_addr, sel_base, sel_max;
    logic [ADDR_W:0]          sel_limit, sel_remain;
    logic [LEN_W-1:0]         sel_len;

    assign launch = (state_reg == ST_IDLE) && (|elig);
    assign done   = (state_reg == ST_BUSY) && burst_done;

    rr_arbiter #(.NPORT(NPORT), .PORT_W(PORT_W)) u_arb (
        .req (elig),
        .ptr (ptr_reg),
        .gnt (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (arb_gnt[k]) arb_idx = PORT_W'(k);
        end
    end

    // Burst length is clipped so a burst never crosses the region end.
    assign sel_addr   = addr_flat[int'(arb_idx)*ADDR_W +: ADDR_W];
    assign sel_base   = port_base[int'(arb_idx)*ADDR_W +: ADDR_W];
    assign sel_max    = port_max[int'(arb_idx)*ADDR_W +: ADDR_W];
    assign sel_limit  = {1'b0, sel_base} + {1'b0, sel_max};
    assign sel_remain = sel_limit - {1'b0, sel_addr};
    assign sel_len    = (sel_remain > BURST_EXT) ? LEN_W'(BURST_LEN) : sel_remain[LEN_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_port
            logic [ADDR_W-1:0] base, maxw, addr_reg;
            logic [LVL_W-1:0]  level;
            logic [ADDR_W:0]   limit, sum;
            logic              pend_reg, granted, wrap_reg, is_win;

            assign base   = port_base[gi*ADDR_W +: ADDR_W];
            assign maxw   = port_max[gi*ADDR_W +: ADDR_W];
            assign level  = port_level[gi*LVL_W +: LVL_W];
            assign limit  = {1'b0, base} + {1'b0, maxw};
            assign sum    = {1'b0, addr_reg} + (ADDR_W+1)'(cmd_len_reg);
            assign is_win = (win_reg == PORT_W'(gi));

            assign elig[gi] = port_en[gi] &&
                (port_dir[gi] ? (level >= LVL_W'(BURST_LEN))
                              : (level <= LVL_W'(FIFO_DEPTH - BURST_LEN)));

            // A reload on the port being served waits for the burst to finish.
            assign granted = ((state_reg != ST_IDLE) && is_win) || (launch && arb_gnt[gi]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    addr_reg <= '0;
                    pend_reg <= 1'b0;
                    wrap_reg <= 1'b0;
                end else begin
                    wrap_reg <= 1'b0;
                    if (done && is_win) begin
                        pend_reg <= 1'b0;
                        if (pend_reg || port_load[gi]) begin
                            addr_reg <= base;
                        end else if (sum >= limit) begin
                            addr_reg <= base;
                            wrap_reg <= 1'b1;
                        end else begin
                            addr_reg <= sum[ADDR_W-1:0];
                        end
                    end else if (port_load[gi]) begin
                        if (granted) pend_reg <= 1'b1;
                        else         addr_reg <= base;
                    end
                end
            end

            assign addr_flat[gi*ADDR_W +: ADDR_W] = addr_reg;
            assign wrap_bus[gi] = wrap_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (|elig)      state_next = ST_CMD;
            ST_CMD:  if (cmd_ready)  state_next = ST_BUSY;
            ST_BUSY: if (burst_done) state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_reg       <= '0;
            ptr_reg       <= '0;
            cmd_write_reg <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_len_reg   <= '0;
        end else if (launch) begin
            win_reg       <= arb_idx;
            ptr_reg       <= (arb_idx == PORT_W'(NPORT-1)) ? '0 : arb_idx + 1'b1;
            cmd_write_reg <= port_dir[arb_idx];
            cmd_addr_reg  <= sel_addr;
            cmd_len_reg   <= sel_len;
        end
    end

    assign cmd_valid = (state_reg == ST_CMD);
    assign cmd_write = cmd_write_reg;
    assign cmd_addr  = cmd_addr_reg;
    assign cmd_len   = cmd_len_reg;
    assign cmd_port  = win_reg;
    assign grant     = (state_reg != ST_IDLE) ? (NPORT'(1) << win_reg) : '0;
    assign wrap      = wrap_bus;
endmodule

// File: doc/sdram_port_scheduler.md
SDRAM_PORT_SCHEDULER -- requirements
Module: sdram_port_scheduler

Interface
REQ-001 SHALL have parameter NPORT, default 4, number of FIFO ports (2..8).
REQ-002 SHALL have parameter ADDR_W, default 24, SDRAM word-address width.
REQ-003 SHALL have parameters BURST_LEN, default 128, and LEN_W, default 9, for burst words and length width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 512; LVL_W = clog2(FIFO_DEPTH)+1; PORT_W = clog2(NPORT).
REQ-005 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: port_en  in  NPORT  port enable; port_dir  in  NPORT  1 = write to SDRAM (drain FIFO), 0 = read.
REQ-007 SHALL have ports: port_base  in  NPORT*ADDR_W  region start; port_max  in  NPORT*ADDR_W  region size in words.
REQ-008 SHALL have ports: port_load  in  NPORT  sync pulse, reload address to base; port_level  in  NPORT*LVL_W  FIFO used words.
REQ-009 SHALL have ports: cmd_valid  out  1; cmd_ready  in  1; cmd_write  out  1; cmd_addr  out  ADDR_W; cmd_len  out  LEN_W; cmd_port  out  PORT_W.
REQ-010 SHALL have ports: burst_done  in  1  controller burst-complete pulse; grant  out  NPORT  one-hot FIFO mux select; wrap  out  NPORT  one-cycle region-wrap pulse.

Function
REQ-011 Eligibility SHALL be: port_en[i] and (dir=1: level >= BURST_LEN; dir=0: level <= FIFO_DEPTH-BURST_LEN).
REQ-012 FSM SHALL have states IDLE, CMD, BUSY; IDLE->CMD when any port eligible, CMD->BUSY on cmd_valid&&cmd_ready, BUSY->IDLE on burst_done.
REQ-013 In IDLE, winner SHALL be chosen round-robin starting at the port after the last granted; cmd_valid rises the cycle after eligibility is sampled.
REQ-014 cmd_valid and all cmd_* SHALL stay stable in CMD until cmd_ready; grant SHALL be one-hot for the winner from CMD entry through the burst_done cycle, zero otherwise.
REQ-015 cmd_addr SHALL be the winner's current address; cmd_len = min(BURST_LEN, base+max-addr); cmd_write = port_dir[winner].
REQ-016 On burst_done: addr += cmd_len; if result >= base+max, addr <= base and wrap[winner] pulses one cycle.
REQ-017 port_load on a non-granted port SHALL set its addr to base next cycle; on the granted port it SHALL be deferred and applied at burst_done instead of the increment, with no wrap pulse.
REQ-018 burst_done outside BUSY and cmd_ready outside CMD SHALL be ignored.
REQ-019 Deasserting port_en or a level change after the grant SHALL NOT abort a command or burst.
REQ-020 Address arithmetic SHALL be ADDR_W+1 bits wide to avoid overflow at the top of the address space.

Reset
REQ-021 rst_n low SHALL asynchronously force: state IDLE, cmd_valid 0, cmd_write 0, cmd_addr 0, cmd_len 0, cmd_port 0, grant 0, wrap 0.
REQ-022 rst_n low SHALL also force all port addresses 0 and the round-robin pointer so that port 0 has first priority.
REQ-023 Reset mid-burst SHALL drop the burst silently; the first post-reset command uses addr 0 unless port_load was applied.

Structure
REQ-024 Package sdram_sched_pkg SHALL hold the state enum and default BURST_LEN/FIFO_DEPTH constants.
REQ-025 Round-robin pick SHALL be a sub-module rr_arbiter (NPORT request vector, pointer in; one-hot grant out), combinational.

Verification
REQ-026 Port0 dir=1, base 0, max 76800, level 128 -> cmd_valid next cycle, addr 0, len 128, write 1; after burst_done next command addr 128.
REQ-027 Port0 base 0, max 300 -> commands at addr 0/len 128, 128/128, 256/44; after third burst_done addr 0 and wrap[0] pulses one cycle.
REQ-028 Ports 0,1,2 continuously eligible -> grant order 0,1,2,0,1; port 3 never granted while port_en[3]=0.
REQ-029 Port3 dir=0, level 385 -> no command; level 384 -> command issued; cmd_ready held low 5 cycles -> cmd_* stable throughout.
REQ-030 port_load on granted port1 (base 1000, addr 1256) during BUSY -> after burst_done next port1 addr 1000, no wrap pulse.
REQ-031 rst_n low in BUSY -> cmd_valid, grant, wrap 0 immediately; after release and eligibility, first command at addr 0 from port 0.
